// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter slice.
//   OP_* : 2-bit function select {sel_hi,sel_lo} of the bitwise logic unit.
//   state_t : arbiter FSM state encoding.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit_4f.sv
// Combinational 4-function bitwise logic unit.
// Ports:
//   op : function select (AND / NAND / OR / NOR)
//   a  : operand A, WIDTH bits
//   b  : operand B, WIDTH bits
//   y  : bitwise result, WIDTH bits
module logic_unit_4f
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      default: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered logic unit between N_REQ
// requesters. One operation is in flight at a time: accept -> execute -> respond.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept (one-hot or zero; only in IDLE)
//   req_op/a/b : per-requester op and operands, requester i in slice i
//   rsp_valid  : result available; rsp_ready : consumer accepts result
//   rsp_data   : result; rsp_id : index of the issuing requester
//   busy       : high whenever the FSM is not IDLE
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. Once rsp_valid is raised, rsp_valid/rsp_data/rsp_id hold stable until
// the edge where rsp_ready is also high. Requesters may withdraw req_valid
// before being granted.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [1:0]        cap_op;
  logic [WIDTH-1:0]  cap_a;
  logic [WIDTH-1:0]  cap_b;
  logic [ID_W-1:0]   cap_id;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH-1:0]  lu_y;

  // Round-robin search: first valid requester starting at last_grant+1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready only in IDLE; reset forces it low even though state may still be
  // non-IDLE during the reset cycle.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && !reset && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Select the winner's op and operands for capture.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  logic_unit_4f #(.WIDTH(WIDTH)) u_lu (
    .op (cap_op),
    .a  (cap_a),
    .b  (cap_b),
    .y  (lu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      cap_op     <= OP_AND;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            // Transfer: operands are frozen here; later input changes are ignored.
            cap_op     <= sel_op;
            cap_a      <= sel_a;
            cap_b      <= sel_b;
            cap_id     <= grant_idx;
            last_grant <= grant_idx;
            busy       <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= lu_y;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // No new accept in this cycle; the next one comes from IDLE.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int WIDTH = 8;
  localparam int N_REQ = 2;
  localparam int ID_W  = 1;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ID_W+WIDTH-1:0] exp_q[$];

  logic_unit_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] lu_model(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return ~(a & b);
      2'b10:   return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          check("rsp_sb", {rsp_id, rsp_data}, exp_q.pop_front());
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({ID_W'(i), lu_model(req_op[2*i +: 2], req_a[WIDTH*i +: WIDTH],
                                              req_b[WIDTH*i +: WIDTH])});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op[2*r +: 2]         = op;
    req_a[WIDTH*r +: WIDTH]  = a;
    req_b[WIDTH*r +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Returns at the negedge of the transfer cycle.
  task automatic wait_ready(input int r);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[r]) return;
    end
    check("timeout_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_any_ready();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) return;
    end
    check("timeout_any_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    check("timeout_rsp", 32'd0, 32'd1);
  endtask

  // Called at the negedge of the transfer cycle T; checks T+1 / T+2, rsp_ready=1.
  task automatic finish_one(input int r, input logic [WIDTH-1:0] expv, input string tag);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check({tag, "_lat1_valid"}, rsp_valid, 32'd0);
    check({tag, "_lat1_busy"}, busy, 32'd1);
    @(negedge clk);
    check({tag, "_lat2_valid"}, rsp_valid, 32'd1);
    check({tag, "_data"}, rsp_data, expv);
    check({tag, "_id"}, rsp_id, r);
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int r, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expv,
                          input string tag);
    set_req(r, op, a, b);
    req_valid[r] = 1'b1;
    wait_ready(r);
    finish_one(r, expv, tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // 1. reset values, req_ready low under reset with a pending request
    set_req(0, 2'b00, 8'hF0, 8'h3C);
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_req_ready", req_ready, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", rsp_id, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 32'h1);

    // 2. all four functions from requester 0
    finish_one(0, 8'h30, "op_and");
    send_one(0, 2'b01, 8'hF0, 8'h3C, 8'hCF, "op_nand");
    send_one(0, 2'b10, 8'hF0, 8'h3C, 8'hFC, "op_or");
    send_one(0, 2'b11, 8'hF0, 8'h3C, 8'h03, "op_nor");
    for (int n = 0; n < 4; n++) begin
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      op = 2'($urandom_range(0, 3));
      a  = WIDTH'($urandom_range(0, 255));
      b  = WIDTH'($urandom_range(0, 255));
      send_one(0, op, a, b, lu_model(op, a, b), "op_rand");
    end

    // 3. both requesters contending: grant alternates 0,1,0,1
    do_reset();
    set_req(0, 2'b10, 8'h11, 8'h22);
    set_req(1, 2'b00, 8'hF0, 8'hFF);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_any_ready();
      check("rr_grant", req_ready, (n % 2 == 1) ? 32'h2 : 32'h1);
      wait_rsp();
      check("rr_id", rsp_id, n % 2);
      check("rr_data", rsp_data, (n % 2 == 1) ? 32'hF0 : 32'h33);
    end
    @(posedge clk);
    #1;
    req_valid = '0;

    // 4. response backpressure
    rsp_ready = 1'b0;
    set_req(1, 2'b11, 8'h0F, 8'h33);
    req_valid = 2'b10;
    wait_ready(1);
    @(posedge clk);
    #1;
    req_valid = '0;
    set_req(0, 2'b00, 8'hFF, 8'h0F);
    req_valid[0] = 1'b1;
    wait_rsp();
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", rsp_valid, 32'd1);
      check("stall_data", rsp_data, 32'hC0);
      check("stall_id", rsp_id, 32'd1);
      check("stall_ready", req_ready, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("no_accept_in_resp", req_ready, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_after_release", busy, 32'd0);
    check("ready_after_release", req_ready, 32'h1);
    finish_one(0, 8'h0F, "after_stall");

    // 5. operands change right after accept
    set_req(1, 2'b10, 8'hAA, 8'h55);
    req_valid = 2'b10;
    wait_ready(1);
    @(posedge clk);
    #1;
    set_req(1, 2'b00, 8'h00, 8'h00);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("capture_valid", rsp_valid, 32'd1);
    check("capture_data", rsp_data, 32'hFF);
    @(posedge clk);
    #1;

    // 6. reset during EXEC discards the op
    set_req(1, 2'b00, 8'hFF, 8'hFF);
    req_valid = 2'b10;
    wait_ready(1);
    @(posedge clk);
    #1;
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    check("exec_busy", busy, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_valid", rsp_valid, 32'd0);
      check("post_rst_busy", busy, 32'd0);
    end
    @(posedge clk);
    #1;
    set_req(0, 2'b01, 8'h0F, 8'hF0);
    set_req(1, 2'b10, 8'h01, 8'h02);
    req_valid = 2'b11;
    @(negedge clk);
    check("post_rst_grant", req_ready, 32'h1);
    finish_one(0, 8'hFF, "post_rst_op");

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("q_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
